rtc3w_responder: RTL and testbench
==================================

# rtc3w_responder

Synthesizable responder for the 3-wire RTC serial bus (CE/RST, SCLK, SIO), LSB first, with a DS1302-style command byte. It holds a 64-byte register file, with clock registers at indices 0-7 and RAM at 32-63, plus a seconds/minutes/hours BCD timekeeper. It stands in for the external RTC chip on the board in simulation and on-FPGA loopback, and is driven by the team's existing 3-wire master.

## Interface
- TICK_DIV, 50_000_000: CLK cycles per timekeeper second (≥2).
- CLK  in  1  system clock (50 MHz).
- RSTn  in  1  reset; one clock; reset is asynchronous and active-low.
- CE  in  1  bus chip enable (master's RST pin), active high.
- SCLK  in  1  bus serial clock.
- SIO  inout  1  bus data; driven only while reading, else high-Z.
- Rx_Cmd  out  8  last complete command byte received.
- Frame_Done  out  1  one-cycle pulse when CE falls after a complete 16-bit frame.

## Operation
- CE, SCLK, SIO pass through 2-flop synchronizers. Edges are detected on the synchronized copies; all logic runs on CLK.
- Command byte: bit0 = 1 read / 0 write; bits5:1 = address; bit6 = 0 clock / 1 RAM; bit7 must be 1. Register index = {cmd[6], cmd[5:1]}.
- States:
  - IDLE: CE low. Clear the bit counter and release SIO. CE rising goes to CMD.
  - CMD: sample SIO on each SCLK rising edge into bit[n], LSB first. After the 8th rising edge, latch Rx_Cmd. Then:
    - cmd[7]=0 → IGNORE.
    - Read → RDATA.
    - Write → WDATA.
  - WDATA: sample 8 bits on rising edges. After the 8th, commit to the register file in the next CLK, subject to write protect. Then → IGNORE.
  - RDATA: load the shift register from the indexed register at entry. On each SCLK falling edge, drive the next bit onto SIO, starting with bit0 on the first falling edge after the command's 8th rising edge. After bit7 has been driven, hold bit7 until CE falls.
  - IGNORE: extra SCLK edges have no effect; wait for CE low.
- CE falling in any state → IDLE:
  - SIO is released.
  - A partial frame is discarded: no write, Rx_Cmd unchanged, no Frame_Done.
- Frame_Done pulses on a CE fall from IGNORE or RDATA only when 16 bits completed: a write, or a read with all 8 bits driven.
- Write protect: register 7 bit7 (WP). While WP=1, writes to every index except 7 are dropped.
- Timekeeper:
  - Register 0 bit7 = CH (halt). While CH=0, the prescaler counts 0..TICK_DIV-1; wrapping produces a tick.
  - On a tick:
    - Seconds (reg0[6:0]) BCD increment; 0x59 → 0x00 with carry.
    - On carry, minutes (reg1) 0x59 → 0x00 with carry.
    - On carry, hours (reg2[5:0]) 0x23 → 0x00; reg2[7:6] is cleared on any hours increment.
  - Non-BCD contents: a low nibble ≥9 wraps to 0 with tens carry.
- Any register write to index 0 clears the prescaler.
- If a write commit and a tick land in the same cycle, the write wins and that tick's increment is dropped entirely.
- The read shift register is a snapshot, so a tick during a read does not alter bits already loaded.

## Timing
- Reset values:
  - Register 0 = 0x80 (halted); all other registers = 0x00.
  - Prescaler = 0, Rx_Cmd = 0x00, Frame_Done = 0, SIO = Z, state = IDLE.
- Input-to-action latency: 3 CLK from a pin edge (2 sync + 1 register). SIO is updated ≤3 CLK after a SCLK pin falling edge, which is well inside the master's 25-cycle half period.
- Write commit: the register is updated 1 CLK after the 16th rising edge is detected.
- SIO release: ≤3 CLK after a CE pin falling edge.
- Rising and falling SCLK edges detected in the same cycle cannot occur; the minimum SCLK half period is 4 CLK.
- Asynchronous reset mid-frame returns everything to reset values immediately, including SIO = Z.

## Test plan
- Write then read: master writes 0x8C←0x25, then reads 0x8D → Read_Data = 0x25, SIO high-Z outside the read phase, and one Frame_Done pulse per frame.
- RAM and index mapping: write 0xC0←0xA5 and 0xFE←0x3C, read 0xC1/0xFF → 0xA5/0x3C; clock register 0 is unchanged.
- Write protect: write 0x8E←0x80, then 0x82←0x11 → reading 0x83 returns 0x00. Then 0x8E←0x00 and 0x82←0x11 → reads 0x11.
- Timekeeper (TICK_DIV=10):
  - Write 0x84←0x23, 0x82←0x59, 0x80←0x58 (CH=0) → after 20 CLK, reg0/1/2 = 0x00/0x00/0x00.
  - With CH=1, the values are frozen for 100 CLK.
- Abort: CE dropped after 12 bits of a write 0x86←0x77 → reg3 unchanged, no Frame_Done, and the next full frame works.
- Invalid command and reset: command 0x0C with bit7=0 → no write and SIO never driven. Assert RSTn low mid-read → SIO = Z and reg0 = 0x80.

Source files
------------

// File: rtl/rtc3w_responder.sv
// 3-wire RTC bus responder (DS1302-style command byte, LSB first) with a 64-byte
// register file and a seconds/minutes/hours BCD timekeeper.
module rtc3w_responder #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       CE,
  input  logic       SCLK,
  inout  wire        SIO,
  output logic [7:0] Rx_Cmd,
  output logic       Frame_Done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // state     | meaning
  // ST_IDLE   | CE low, bit counter cleared, SIO released
  // ST_CMD    | shifting in the command byte
  // ST_WDATA  | shifting in the write data byte
  // ST_RDATA  | driving the snapshot byte on SCLK falling edges
  // ST_IGNORE | frame consumed, waiting for CE low
  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_WDATA, ST_RDATA, ST_IGNORE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      ce_sync_q, ce_sync_d, sclk_sync_q, sclk_sync_d, sio_sync_q, sio_sync_d;
  logic            ce_prev_q, ce_prev_d, sclk_prev_q, sclk_prev_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [3:0]      rd_cnt_q, rd_cnt_d;
  logic [7:0]      shift_q, shift_d, rd_shift_q, rd_shift_d, rx_cmd_q, rx_cmd_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [5:0]      wr_idx_q, wr_idx_d;
  logic            wr_pend_q, wr_pend_d, frame_ok_q, frame_ok_d, frame_done_q, frame_done_d;
  logic            sio_oe_q, sio_oe_d, sio_out_q, sio_out_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      regs_q [64];
  logic [7:0]      regs_d [64];

  logic            ce_rise, ce_fall, sclk_rise, sclk_fall, tick, wr_en;
  logic [7:0]      in_byte;
  logic [8:0]      sec_n, min_n, hr_n;

  // Returns {carry, next}; a low nibble of 9 or more rolls into the tens digit.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim)            return 9'h100;
    else if (v[3:0] >= 4'd9) return {1'b0, v[7:4] + 4'd1, 4'd0};
    else                     return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  assign ce_rise   =  ce_sync_q[1]   & ~ce_prev_q;
  assign ce_fall   = ~ce_sync_q[1]   &  ce_prev_q;
  assign sclk_rise =  sclk_sync_q[1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q[1] &  sclk_prev_q;
  assign in_byte   = {sio_sync_q[1], shift_q[7:1]};

  always_comb begin
    ce_sync_d    = {ce_sync_q[0], CE};
    sclk_sync_d  = {sclk_sync_q[0], SCLK};
    sio_sync_d   = {sio_sync_q[0], SIO};
    ce_prev_d    = ce_sync_q[1];
    sclk_prev_d  = sclk_sync_q[1];
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    shift_d      = shift_q;
    rd_shift_d   = rd_shift_q;
    rx_cmd_d     = rx_cmd_q;
    wr_data_d    = wr_data_q;
    wr_idx_d     = wr_idx_q;
    wr_pend_d    = 1'b0;
    frame_ok_d   = frame_ok_q;
    frame_done_d = 1'b0;
    sio_oe_d     = sio_oe_q;
    sio_out_d    = sio_out_q;

    if (ce_fall) begin
      state_d      = ST_IDLE;
      sio_oe_d     = 1'b0;
      bit_cnt_d    = 3'd0;
      frame_ok_d   = 1'b0;
      frame_done_d = frame_ok_q && (state_q == ST_IGNORE || state_q == ST_RDATA);
    end else begin
      case (state_q)
        ST_IDLE: begin
          bit_cnt_d  = 3'd0;
          sio_oe_d   = 1'b0;
          frame_ok_d = 1'b0;
          if (ce_rise) state_d = ST_CMD;
        end
        ST_CMD: if (sclk_rise) begin
          shift_d   = in_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_cmd_d = in_byte;
            wr_idx_d = {in_byte[6], in_byte[5:1]};
            if (!in_byte[7]) state_d = ST_IGNORE;
            else if (in_byte[0]) begin
              state_d    = ST_RDATA;
              rd_cnt_d   = 4'd0;
              rd_shift_d = regs_q[{in_byte[6], in_byte[5:1]}];
            end else state_d = ST_WDATA;
          end
        end
        ST_WDATA: if (sclk_rise) begin
          shift_d   = in_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            wr_data_d  = in_byte;
            wr_pend_d  = 1'b1;
            frame_ok_d = 1'b1;
            state_d    = ST_IGNORE;
          end
        end
        ST_RDATA: if (sclk_fall && rd_cnt_q != 4'd8) begin
          sio_oe_d   = 1'b1;
          sio_out_d  = rd_shift_q[0];
          rd_shift_d = {1'b0, rd_shift_q[7:1]};
          rd_cnt_d   = rd_cnt_q + 4'd1;
          if (rd_cnt_q == 4'd7) frame_ok_d = 1'b1;
        end
        default: ;
      endcase
    end

    regs_d = regs_q;
    presc_d = presc_q;
    tick = 1'b0;
    sec_n = 9'h000;
    min_n = 9'h000;
    hr_n = 9'h000;
    if (!regs_q[0][7]) begin
      if (presc_q == PW'(TICK_DIV - 1)) begin
        presc_d = '0;
        tick    = 1'b1;
      end else presc_d = presc_q + 1'b1;
    end

    // A committed write takes priority and swallows a coincident tick.
    wr_en = wr_pend_q && (!regs_q[7][7] || wr_idx_q == 6'd7);
    if (wr_en) begin
      regs_d[wr_idx_q] = wr_data_q;
      if (wr_idx_q == 6'd0) presc_d = '0;
    end else if (tick) begin
      sec_n = bcd_inc({1'b0, regs_q[0][6:0]}, 8'h59);
      regs_d[0] = {regs_q[0][7], sec_n[6:0]};
      if (sec_n[8]) begin
        min_n = bcd_inc(regs_q[1], 8'h59);
        regs_d[1] = min_n[7:0];
        if (min_n[8]) begin
          hr_n = bcd_inc({2'b00, regs_q[2][5:0]}, 8'h23);
          regs_d[2] = {2'b00, hr_n[5:0]};
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= ST_IDLE;
      ce_sync_q    <= 2'b00;
      sclk_sync_q  <= 2'b00;
      sio_sync_q   <= 2'b00;
      ce_prev_q    <= 1'b0;
      sclk_prev_q  <= 1'b0;
      bit_cnt_q    <= 3'd0;
      rd_cnt_q     <= 4'd0;
      shift_q      <= 8'h00;
      rd_shift_q   <= 8'h00;
      rx_cmd_q     <= 8'h00;
      wr_data_q    <= 8'h00;
      wr_idx_q     <= 6'd0;
      wr_pend_q    <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_done_q <= 1'b0;
      sio_oe_q     <= 1'b0;
      sio_out_q    <= 1'b0;
      presc_q      <= '0;
      for (int i = 0; i < 64; i++) regs_q[i] <= (i == 0) ? 8'h80 : 8'h00;
    end else begin
      state_q      <= state_d;
      ce_sync_q    <= ce_sync_d;
      sclk_sync_q  <= sclk_sync_d;
      sio_sync_q   <= sio_sync_d;
      ce_prev_q    <= ce_prev_d;
      sclk_prev_q  <= sclk_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      shift_q      <= shift_d;
      rd_shift_q   <= rd_shift_d;
      rx_cmd_q     <= rx_cmd_d;
      wr_data_q    <= wr_data_d;
      wr_idx_q     <= wr_idx_d;
      wr_pend_q    <= wr_pend_d;
      frame_ok_q   <= frame_ok_d;
      frame_done_q <= frame_done_d;
      sio_oe_q     <= sio_oe_d;
      sio_out_q    <= sio_out_d;
      presc_q      <= presc_d;
      for (int i = 0; i < 64; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign SIO        = sio_oe_q ? sio_out_q : 1'bz;
  assign Rx_Cmd     = rx_cmd_q;
  assign Frame_Done = frame_done_q;

endmodule

// File: tb/tb_rtc3w_responder.sv
// Directed bench for rtc3w_responder: the bench plays the 3-wire master; SIO has a
// pull-up so a released line reads 1.
module tb_rtc3w_responder;
  localparam int H = 6;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       CE = 1'b0;
  logic       SCLK = 1'b0;
  logic       tb_en = 1'b0;
  logic       tb_drv = 1'b0;
  wire        SIO;
  logic [7:0] Rx_Cmd;
  logic       Frame_Done;
  logic [7:0] rd;
  int         checks = 0;
  int         errors = 0;
  int         fd_cnt = 0;
  int         f0 = 0;
  int         tk_n = 0;

  pullup (SIO);
  assign SIO = tb_en ? tb_drv : 1'bz;

  rtc3w_responder #(.TICK_DIV(10)) dut (
    .CLK(CLK), .RSTn(RSTn), .CE(CE), .SCLK(SCLK), .SIO(SIO),
    .Rx_Cmd(Rx_Cmd), .Frame_Done(Frame_Done)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (Frame_Done === 1'b1) fd_cnt++;

  initial begin
    #500_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic shift_out(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      tb_en = 1'b1; tb_drv = b[i];
      wait_clk(H); SCLK = 1'b1;
      wait_clk(H); SCLK = 1'b0;
    end
  endtask

  task automatic wr_frame(input logic [7:0] cmd, input logic [7:0] data);
    CE = 1'b1; wait_clk(H);
    shift_out(cmd, 8);
    shift_out(data, 8);
    tb_en = 1'b0; wait_clk(H);
    CE = 1'b0; wait_clk(H);
  endtask

  task automatic rd_frame(input logic [7:0] cmd, output logic [7:0] data);
    CE = 1'b1; wait_clk(H);
    shift_out(cmd, 8);
    tb_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_clk(H); data[i] = SIO; SCLK = 1'b1;
      wait_clk(H); SCLK = 1'b0;
    end
    wait_clk(H); CE = 1'b0; wait_clk(H);
  endtask

  initial begin
    wait_clk(3);
    chk("rst_rx_cmd", Rx_Cmd, 8'h00);
    chk("rst_frame_done", {7'd0, Frame_Done}, 8'h00);
    chk("rst_sio_z", {7'd0, SIO}, 8'h01);
    chk("rst_reg0", dut.regs_q[0], 8'h80);
    RSTn = 1'b1; wait_clk(3);

    // write then read
    f0 = fd_cnt; wr_frame(8'h8C, 8'h25);
    chk("wr_frame_done", 8'(fd_cnt - f0), 8'h01);
    chk("wr_sio_z", {7'd0, SIO}, 8'h01);
    f0 = fd_cnt; rd_frame(8'h8D, rd);
    chk("rd_8d", rd, 8'h25);
    chk("rd_rx_cmd", Rx_Cmd, 8'h8D);
    chk("rd_frame_done", 8'(fd_cnt - f0), 8'h01);
    chk("rd_sio_z", {7'd0, SIO}, 8'h01);

    // RAM and index mapping
    wr_frame(8'hC0, 8'hA5);
    wr_frame(8'hFE, 8'h3C);
    rd_frame(8'hC1, rd); chk("ram_c1", rd, 8'hA5);
    rd_frame(8'hFF, rd); chk("ram_ff", rd, 8'h3C);
    rd_frame(8'h81, rd); chk("reg0_kept", rd, 8'h80);

    // write protect
    wr_frame(8'h8E, 8'h80);
    wr_frame(8'h82, 8'h11);
    rd_frame(8'h83, rd); chk("wp_dropped", rd, 8'h00);
    rd_frame(8'h8F, rd); chk("wp_reg7", rd, 8'h80);
    wr_frame(8'h8E, 8'h00);
    wr_frame(8'h82, 8'h11);
    rd_frame(8'h83, rd); chk("wp_cleared", rd, 8'h11);

    // abort after 12 bits
    f0 = fd_cnt;
    CE = 1'b1; wait_clk(H);
    shift_out(8'h86, 8);
    shift_out(8'h77, 4);
    tb_en = 1'b0; wait_clk(H); CE = 1'b0; wait_clk(H);
    chk("abort_frame_done", 8'(fd_cnt - f0), 8'h00);
    chk("abort_sio_z", {7'd0, SIO}, 8'h01);
    rd_frame(8'h87, rd); chk("abort_reg3", rd, 8'h00);
    wr_frame(8'h86, 8'h77);
    rd_frame(8'h87, rd); chk("after_abort_reg3", rd, 8'h77);

    // invalid command (bit7 = 0)
    f0 = fd_cnt; wr_frame(8'h0C, 8'h5A);
    chk("inv_frame_done", 8'(fd_cnt - f0), 8'h00);
    chk("inv_rx_cmd", Rx_Cmd, 8'h0C);
    f0 = fd_cnt; rd_frame(8'h0C, rd);
    chk("inv_sio_undriven", rd, 8'hFF);
    chk("inv_rd_frame_done", 8'(fd_cnt - f0), 8'h00);
    rd_frame(8'h8D, rd); chk("inv_reg6", rd, 8'h25);

    // timekeeper rollover 23:59:58 -> 00:00:00 after two ticks
    wr_frame(8'h84, 8'h23);
    wr_frame(8'h82, 8'h59);
    fork
      wr_frame(8'h80, 8'h58);
      begin
        tk_n = 0;
        while (dut.regs_q[0] !== 8'h58 && tk_n < 2000) begin
          wait_clk(1); tk_n++;
        end
        chk("tk_commit", dut.regs_q[0], 8'h58);
        wait_clk(19);
        chk("tk_sec_19", dut.regs_q[0], 8'h59);
        wait_clk(1);
        chk("tk_sec_20", dut.regs_q[0], 8'h00);
        chk("tk_min_20", dut.regs_q[1], 8'h00);
        chk("tk_hr_20", dut.regs_q[2], 8'h00);
      end
    join

    // halted: frozen
    wr_frame(8'h80, 8'h85);
    wait_clk(100);
    chk("halt_reg0", dut.regs_q[0], 8'h85);
    rd_frame(8'h81, rd); chk("halt_rd_81", rd, 8'h85);
    rd_frame(8'h83, rd); chk("halt_rd_83", rd, 8'h00);
    rd_frame(8'h85, rd); chk("halt_rd_85", rd, 8'h00);

    // async reset in the middle of a read of 0x85 (bit3 = 0 being driven)
    CE = 1'b1; wait_clk(H);
    shift_out(8'h81, 8);
    tb_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_clk(H); SCLK = 1'b1;
      wait_clk(H); SCLK = 1'b0;
    end
    wait_clk(H);
    chk("pre_rst_sio_bit3", {7'd0, SIO}, 8'h00);
    RSTn = 1'b0; #1;
    chk("mid_rst_sio_z", {7'd0, SIO}, 8'h01);
    chk("mid_rst_reg0", dut.regs_q[0], 8'h80);
    chk("mid_rst_rx_cmd", Rx_Cmd, 8'h00);
    chk("mid_rst_frame_done", {7'd0, Frame_Done}, 8'h00);
    CE = 1'b0; SCLK = 1'b0;
    wait_clk(5); RSTn = 1'b1; wait_clk(5);
    rd_frame(8'h81, rd); chk("post_rst_reg0", rd, 8'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
